// File: rtl/tpu_fixed_pkg.sv
// Shared Q8.8 fixed-point helpers, widths and the bias-gradient FSM state type.
package tpu_fixed_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_W    = 8;
  localparam int ACC_W     = 24;
  localparam int ROW_CNT_W = 8;
  // Widest value ever handed to sat_to_data (callers sign-extend to this).
  localparam int SAT_IN_W  = 2 * DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } bias_grad_state_t;

  // Signed clamp to DATA_W: in range only if all bits above the DATA_W sign bit match it.
  function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [SAT_IN_W-1:0] v);
    logic [SAT_IN_W-DATA_W:0] top;
    top = v[SAT_IN_W-1:DATA_W-1];
    if ((&top) || (~|top)) begin
      return v[DATA_W-1:0];
    end else if (v[SAT_IN_W-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // Q8.8 * Q8.8 -> Q8.8, round half up (toward +inf on ties).
  function automatic logic signed [2*DATA_W-1:0] q88_round_mul(input logic signed [DATA_W-1:0] a,
                                                               input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] half;
    half = '0;
    half[FRAC_W-1] = 1'b1;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return (prod + half) >>> FRAC_W;
  endfunction

endpackage

// File: rtl/bias_grad_accum_if.sv
// Port bundle for the bias-gradient accumulator: batch control, two dZ lanes, results.
interface bias_grad_accum_if;
  import tpu_fixed_pkg::*;

  // dZ lanes are valid-only (no ready): a sample is consumed on a clock edge where its
  // valid is high, the FSM is in ACCUM and that column still needs rows; otherwise dropped.
  logic                    grad_start_in;
  logic [ROW_CNT_W-1:0]    grad_batch_rows_in;
  logic [DATA_W-1:0]       grad_lr_in;
  logic [DATA_W-1:0]       grad_bias_in_1;
  logic [DATA_W-1:0]       grad_bias_in_2;
  logic [DATA_W-1:0]       grad_dz_in_1;
  logic [DATA_W-1:0]       grad_dz_in_2;
  logic                    grad_dz_valid_in_1;
  logic                    grad_dz_valid_in_2;
  logic                    grad_busy_out;
  logic                    grad_done_out;
  logic [DATA_W-1:0]       grad_bias_grad_out_1;
  logic [DATA_W-1:0]       grad_bias_grad_out_2;
  logic [DATA_W-1:0]       grad_bias_new_out_1;
  logic [DATA_W-1:0]       grad_bias_new_out_2;
  bias_grad_state_t        grad_state_dbg;

  modport master (
    output grad_start_in, grad_batch_rows_in, grad_lr_in, grad_bias_in_1, grad_bias_in_2,
           grad_dz_in_1, grad_dz_in_2, grad_dz_valid_in_1, grad_dz_valid_in_2,
    input  grad_busy_out, grad_done_out, grad_bias_grad_out_1, grad_bias_grad_out_2,
           grad_bias_new_out_1, grad_bias_new_out_2, grad_state_dbg
  );

  modport slave (
    input  grad_start_in, grad_batch_rows_in, grad_lr_in, grad_bias_in_1, grad_bias_in_2,
           grad_dz_in_1, grad_dz_in_2, grad_dz_valid_in_1, grad_dz_valid_in_2,
    output grad_busy_out, grad_done_out, grad_bias_grad_out_1, grad_bias_grad_out_2,
           grad_bias_new_out_1, grad_bias_new_out_2, grad_state_dbg
  );

endinterface

// File: rtl/bias_grad_accum_child.sv
// One feature column: saturating dZ accumulator, row counter and the SGD bias update.
module bias_grad_child
  import tpu_fixed_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accum_en,
  input  logic                     update_en,
  input  logic [ROW_CNT_W-1:0]     rows,
  input  logic signed [DATA_W-1:0] lr,
  input  logic signed [DATA_W-1:0] bias_in,
  input  logic signed [DATA_W-1:0] dz,
  input  logic                     dz_valid,
  output logic                     col_done_next,
  output logic signed [DATA_W-1:0] grad_out,
  output logic signed [DATA_W-1:0] new_out
);

  localparam int STEP_W = DATA_W + 1;
  localparam int NEW_W  = DATA_W + 2;

  logic signed [ACC_W-1:0]    acc, acc_nxt;
  logic [ROW_CNT_W-1:0]       cnt, cnt_nxt;
  logic                       sat_q, sat_nxt;
  logic signed [DATA_W-1:0]   bias_q;
  logic                       take;
  logic signed [ACC_W:0]      sum;
  logic signed [DATA_W-1:0]   grad_sat;
  logic signed [2*DATA_W-1:0] step_full;
  logic signed [STEP_W-1:0]   step_c;
  logic signed [NEW_W-1:0]    new_wide;
  logic signed [DATA_W-1:0]   new_sat;

  assign take = accum_en && dz_valid && (cnt < rows);
  assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(dz);

  // Once clamped the accumulator never moves again for this batch.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    sat_nxt = sat_q;
    if (take) begin
      cnt_nxt = cnt + ROW_CNT_W'(1);
      if (!sat_q) begin
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          sat_nxt = 1'b1;
        end else begin
          acc_nxt = sum[ACC_W-1:0];
        end
      end
    end
  end

  assign col_done_next = (cnt_nxt == rows);

  // A step beyond +/-2^16 saturates the new bias anyway, so clamp it before the narrow subtract.
  always_comb begin
    grad_sat  = sat_to_data(SAT_IN_W'(acc));
    step_full = q88_round_mul(lr, grad_sat);
    if ((&step_full[2*DATA_W-1:STEP_W-1]) || (~|step_full[2*DATA_W-1:STEP_W-1])) begin
      step_c = step_full[STEP_W-1:0];
    end else if (step_full[2*DATA_W-1]) begin
      step_c = {1'b1, {(STEP_W-1){1'b0}}};
    end else begin
      step_c = {1'b0, {(STEP_W-1){1'b1}}};
    end
    new_wide = NEW_W'(bias_q) - NEW_W'(step_c);
    new_sat  = sat_to_data(SAT_IN_W'(new_wide));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sat_q    <= 1'b0;
      bias_q   <= '0;
      grad_out <= '0;
      new_out  <= '0;
    end else if (clear) begin
      acc    <= '0;
      cnt    <= '0;
      sat_q  <= 1'b0;
      bias_q <= bias_in;
    end else begin
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat_q <= sat_nxt;
      if (update_en) begin
        grad_out <= grad_sat;
        new_out  <= new_sat;
      end
    end
  end

endmodule

// File: rtl/bias_grad_accum.sv
// Bias-gradient reduction over a batch for two columns, with SGD bias write-back values.
module bias_grad_accum
  import tpu_fixed_pkg::*;
(
  input logic               clk,
  input logic               rst,
  bias_grad_accum_if.slave  bus
);

  bias_grad_state_t      state, state_nxt;
  logic [ROW_CNT_W-1:0]  rows_q;
  logic [DATA_W-1:0]     lr_q;
  logic                  start_ok;
  logic                  done_1, done_2;
  logic [DATA_W-1:0]     grad_1, grad_2, new_1, new_2;

  assign start_ok = (state == ST_IDLE) && bus.grad_start_in && (bus.grad_batch_rows_in != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rows_q <= '0;
      lr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        rows_q <= bus.grad_batch_rows_in;
        lr_q   <= bus.grad_lr_in;
      end
    end
  end

  // Columns finish independently; leave ACCUM on the edge that completes the slower one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (done_1 && done_2) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  bias_grad_child u_col_1 (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .accum_en      (state == ST_ACCUM),
    .update_en     (state == ST_UPDATE),
    .rows          (rows_q),
    .lr            (lr_q),
    .bias_in       (bus.grad_bias_in_1),
    .dz            (bus.grad_dz_in_1),
    .dz_valid      (bus.grad_dz_valid_in_1),
    .col_done_next (done_1),
    .grad_out      (grad_1),
    .new_out       (new_1)
  );

  bias_grad_child u_col_2 (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .accum_en      (state == ST_ACCUM),
    .update_en     (state == ST_UPDATE),
    .rows          (rows_q),
    .lr            (lr_q),
    .bias_in       (bus.grad_bias_in_2),
    .dz            (bus.grad_dz_in_2),
    .dz_valid      (bus.grad_dz_valid_in_2),
    .col_done_next (done_2),
    .grad_out      (grad_2),
    .new_out       (new_2)
  );

  assign bus.grad_busy_out        = (state != ST_IDLE);
  assign bus.grad_done_out        = (state == ST_DONE);
  assign bus.grad_bias_grad_out_1 = grad_1;
  assign bus.grad_bias_grad_out_2 = grad_2;
  assign bus.grad_bias_new_out_1  = new_1;
  assign bus.grad_bias_new_out_2  = new_2;
  assign bus.grad_state_dbg       = state;

endmodule
